// File: rtl/ofdm_frame_sequencer_if.sv
// Per-sample streaming bus: 32-bit data with valid and packet delimiters.
// The producer of a stream uses the master modport, the consumer uses slave.
interface ofdm_frame_sequencer_if;
  logic [31:0] data;
  logic        valid;
  logic        startofpacket;
  logic        endofpacket;

  modport master (output data, output valid, output startofpacket, output endofpacket);
  modport slave  (input data, input valid, input startofpacket, input endofpacket);
endinterface

// File: rtl/ofdm_frame_sequencer.sv
// Groups per-symbol samples from the symbol-sync block into frames of
// SYMBOLS_PER_FRAME symbols, checks symbol framing, runs a watchdog and drives
// the restart request back to the symbol-sync block.
module ofdm_frame_sequencer #(
  parameter int unsigned SYMBOLS_PER_FRAME = 8,
  parameter int unsigned SYMBOL_LENGTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 1024,
  parameter int unsigned GUARD_CYCLES      = 4
) (
  input  logic                          clock_clk,
  input  logic                          reset_reset,
  input  logic                          ctrl_enable,
  input  logic                          ctrl_abort,
  input  logic                          sync_pre_sampling,
  ofdm_frame_sequencer_if.slave         asi_in0,
  output logic                          sync_reset,
  ofdm_frame_sequencer_if.master        aso_out0,
  output logic                          frame_active,
  output logic                          err_timeout,
  output logic                          err_protocol,
  output logic [15:0]                   frame_count
);

  localparam logic [15:0] LastSample = 16'(SYMBOL_LENGTH - 1);
  localparam logic [7:0]  LastSymbol = 8'(SYMBOLS_PER_FRAME - 1);
  localparam logic [31:0] WdLimit    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GuardLast  = 16'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StHunt, StFrame, StGuard, StResync} state_e;

  state_e      r_state, w_state_next;
  logic [15:0] r_samp_cnt, w_samp_cnt_next;
  logic [7:0]  r_sym_idx, w_sym_idx_next;
  logic        r_sym_open, w_sym_open_next;
  logic [31:0] r_wdog, w_wdog_next;
  logic [15:0] r_guard_cnt, w_guard_cnt_next;
  logic        r_abort_seen, w_abort_seen_next;
  logic [15:0] r_frame_cnt, w_frame_cnt_next;
  logic [31:0] r_out_data, w_out_data_next;
  logic        r_out_valid, w_out_valid_next;
  logic        r_out_sop, w_out_sop_next;
  logic        r_out_eop, w_out_eop_next;
  logic        r_err_to, w_err_to_next;
  logic        r_err_proto, w_err_proto_next;

  logic [15:0] w_idx;
  logic        w_take;
  logic        w_bad_sample;

  // Index of the incoming sample within its symbol; sop restarts the count.
  assign w_idx = asi_in0.startofpacket ? 16'd0 : r_samp_cnt + 16'd1;

  // Samples consumed: everything valid in FRAME, only a sop in HUNT.
  assign w_take = asi_in0.valid &&
                  ((r_state == StFrame) ||
                   (r_state == StHunt && ctrl_enable && asi_in0.startofpacket));

  // r_sym_open is set between a symbol's sop and its eop.
  assign w_bad_sample = (asi_in0.endofpacket && (w_idx != LastSample)) ||
                        (asi_in0.startofpacket && r_sym_open) ||
                        (!asi_in0.startofpacket && !r_sym_open);

  // Next-state, counters and registered outputs.
  always_comb begin
    w_state_next      = r_state;
    w_samp_cnt_next   = r_samp_cnt;
    w_sym_idx_next    = r_sym_idx;
    w_sym_open_next   = r_sym_open;
    w_wdog_next       = r_wdog;
    w_guard_cnt_next  = r_guard_cnt;
    w_abort_seen_next = r_abort_seen;
    w_frame_cnt_next  = r_frame_cnt;
    w_out_data_next   = r_out_data;
    w_out_valid_next  = 1'b0;
    w_out_sop_next    = 1'b0;
    w_out_eop_next    = 1'b0;
    w_err_to_next     = 1'b0;
    w_err_proto_next  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (ctrl_enable) w_state_next = StHunt;
      end
      StHunt: begin
        if (!ctrl_enable) begin
          w_state_next = StIdle;
        end else if (!w_take && sync_pre_sampling) begin
          if (r_wdog == WdLimit) begin
            w_err_to_next = 1'b1;
            w_state_next  = StResync;
          end else begin
            w_wdog_next = r_wdog + 32'd1;
          end
        end
      end
      StFrame: begin
        if (!w_take) begin
          if (r_wdog == WdLimit) begin
            w_err_to_next = 1'b1;
            w_state_next  = StResync;
          end else begin
            w_wdog_next = r_wdog + 32'd1;
          end
        end
      end
      StGuard, StResync: begin
        if (r_guard_cnt == GuardLast) begin
          if (ctrl_enable && !r_abort_seen) w_state_next = StHunt;
          else                              w_state_next = StIdle;
          w_abort_seen_next = 1'b0;
        end else begin
          w_guard_cnt_next = r_guard_cnt + 16'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_take) begin
      w_wdog_next = 32'd0;
      if (w_bad_sample) begin
        w_err_proto_next = 1'b1;
        w_state_next     = StResync;
      end else begin
        w_out_valid_next = 1'b1;
        w_out_data_next  = asi_in0.data;
        w_out_sop_next   = asi_in0.startofpacket && (r_sym_idx == 8'd0);
        w_samp_cnt_next  = w_idx;
        w_sym_open_next  = !asi_in0.endofpacket;
        w_state_next     = StFrame;
        if (asi_in0.endofpacket) begin
          if (r_sym_idx == LastSymbol) begin
            w_out_eop_next   = 1'b1;
            w_frame_cnt_next = r_frame_cnt + 16'd1;
            w_state_next     = StGuard;
          end else begin
            w_sym_idx_next = r_sym_idx + 8'd1;
          end
        end
      end
    end

    // Abort overrides every other event, including a completing eop.
    if (ctrl_abort && (r_state != StIdle)) begin
      w_state_next      = StResync;
      w_abort_seen_next = 1'b1;
      w_guard_cnt_next  = 16'd0;
      w_frame_cnt_next  = r_frame_cnt;
      w_out_valid_next  = 1'b0;
      w_out_sop_next    = 1'b0;
      w_out_eop_next    = 1'b0;
      w_err_to_next     = 1'b0;
      w_err_proto_next  = 1'b0;
    end

    if (w_state_next != StFrame) begin
      w_samp_cnt_next = 16'd0;
      w_sym_idx_next  = 8'd0;
      w_sym_open_next = 1'b0;
    end
    if ((w_state_next != StHunt) && (w_state_next != StFrame)) w_wdog_next = 32'd0;
    if (w_state_next != r_state) w_guard_cnt_next = 16'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      r_state      <= StIdle;
      r_samp_cnt   <= 16'd0;
      r_sym_idx    <= 8'd0;
      r_sym_open   <= 1'b0;
      r_wdog       <= 32'd0;
      r_guard_cnt  <= 16'd0;
      r_abort_seen <= 1'b0;
      r_frame_cnt  <= 16'd0;
      r_out_data   <= 32'd0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_err_to     <= 1'b0;
      r_err_proto  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_samp_cnt   <= w_samp_cnt_next;
      r_sym_idx    <= w_sym_idx_next;
      r_sym_open   <= w_sym_open_next;
      r_wdog       <= w_wdog_next;
      r_guard_cnt  <= w_guard_cnt_next;
      r_abort_seen <= w_abort_seen_next;
      r_frame_cnt  <= w_frame_cnt_next;
      r_out_data   <= w_out_data_next;
      r_out_valid  <= w_out_valid_next;
      r_out_sop    <= w_out_sop_next;
      r_out_eop    <= w_out_eop_next;
      r_err_to     <= w_err_to_next;
      r_err_proto  <= w_err_proto_next;
    end
  end

  assign sync_reset             = (r_state == StIdle) || (r_state == StGuard) ||
                                  (r_state == StResync);
  assign frame_active           = (r_state == StFrame);
  assign aso_out0.data          = r_out_data;
  assign aso_out0.valid         = r_out_valid;
  assign aso_out0.startofpacket = r_out_sop;
  assign aso_out0.endofpacket   = r_out_eop;
  assign err_timeout            = r_err_to;
  assign err_protocol           = r_err_proto;
  assign frame_count            = r_frame_cnt;

endmodule
